seq_verifier: RTL and testbench

SEQ_VERIFIER -- requirements
Module: seq_verifier

---
 rtl/seq_verifier.sv | 216 +++++++++++++++++++++
 tb/tb_seq_verifier.sv | 332 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/seq_verifier.sv
// seq_verifier: credential checker. A request carries a username and a
// password; the password is hashed one byte per cycle with 32-bit FNV-1a,
// then compared against a small credential table. Each entry counts
// consecutive failures and locks itself after MAX_FAIL of them.
//
// Ports:
//   clk, rst_n              clock, async active-low reset
//   req_valid/req_ready     request handshake (ready only in IDLE)
//   req_user, req_pass      candidate credentials, byte 0 = bits[7:0]
//   resp_valid/resp_ready   response handshake
//   resp_pass, resp_locked  verdict, held stable while resp_valid && !resp_ready
//   cfg_we/addr/user/hash   table write, honoured only in IDLE

// One credential table entry: storage, user compare, fail/lock bookkeeping.
module seq_verifier_entry #(
  parameter int DATA_W   = 64,
  parameter int MAX_FAIL = 3
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              wr,
  input  logic [DATA_W-1:0] wr_user,
  input  logic [31:0]       wr_hash,
  input  logic              ok,
  input  logic              fail,
  input  logic [DATA_W-1:0] cmp_user,
  output logic              hit,
  output logic [31:0]       hash,
  output logic [3:0]        fail_cnt,
  output logic              locked
);
  localparam logic [3:0] MF = 4'(MAX_FAIL);

  logic              valid;
  logic [DATA_W-1:0] user;

  assign hit = valid && (user == cmp_user);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid    <= 1'b0;
      user     <= '0;
      hash     <= '0;
      fail_cnt <= '0;
      locked   <= 1'b0;
    end else if (wr) begin
      valid    <= |wr_user;   // an all-zero username marks the slot empty
      user     <= wr_user;
      hash     <= wr_hash;
      fail_cnt <= '0;
      locked   <= 1'b0;
    end else if (ok) begin
      fail_cnt <= '0;
    end else if (fail && fail_cnt < MF) begin
      fail_cnt <= fail_cnt + 4'd1;
      if (fail_cnt + 4'd1 == MF) locked <= 1'b1;
    end
  end
endmodule

module seq_verifier #(
  parameter int DATA_W   = 64,
  parameter int USERS    = 8,
  parameter int MAX_FAIL = 3
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     req_valid,
  output logic                     req_ready,
  input  logic [DATA_W-1:0]        req_user,
  input  logic [DATA_W-1:0]        req_pass,
  output logic                     resp_valid,
  input  logic                     resp_ready,
  output logic                     resp_pass,
  output logic                     resp_locked,
  input  logic                     cfg_we,
  input  logic [$clog2(USERS)-1:0] cfg_addr,
  input  logic [DATA_W-1:0]        cfg_user,
  input  logic [31:0]              cfg_hash
);
  localparam int          NB       = DATA_W / 8;
  localparam int          IW       = $clog2(NB + 1);
  localparam int          AW       = $clog2(USERS);
  localparam logic [3:0]  MF       = 4'(MAX_FAIL);
  localparam logic [31:0] FNV_OFF  = 32'h811C9DC5;
  localparam logic [31:0] FNV_PRIM = 32'h01000193;

  typedef enum logic [1:0] {IDLE, HASH, CHECK, RESP} state_t;

  state_t            state;
  logic [DATA_W-1:0] user_q, pass_q;
  logic [IW-1:0]     len_q, i;
  logic [31:0]       h;

  assign req_ready = (state == IDLE);

  // Password length: bytes before the first 0x00 byte.
  logic [IW-1:0] len_c;
  logic          zfound;
  always_comb begin
    len_c  = IW'(NB);
    zfound = 1'b0;
    for (int b = 0; b < NB; b++) begin
      if (!zfound && req_pass[8*b +: 8] == 8'h00) begin
        len_c  = IW'(b);
        zfound = 1'b1;
      end
    end
  end

  logic [7:0] byte_cur;
  always_comb begin
    byte_cur = '0;
    for (int b = 0; b < NB; b++)
      if (i == IW'(b)) byte_cur = pass_q[8*b +: 8];
  end

  logic [31:0] h_next;
  assign h_next = (h ^ {24'b0, byte_cur}) * FNV_PRIM;

  // Table
  logic [USERS-1:0]       ent_hit, wr_vec, ok_vec, fail_vec;
  logic [USERS-1:0][31:0] ent_hash;
  logic [USERS-1:0][3:0]  ent_fail;
  logic [USERS-1:0]       ent_locked;

  for (genvar k = 0; k < USERS; k++) begin : g_ent
    seq_verifier_entry #(.DATA_W(DATA_W), .MAX_FAIL(MAX_FAIL)) u_ent (
      .clk      (clk),
      .rst_n    (rst_n),
      .wr       (wr_vec[k]),
      .wr_user  (cfg_user),
      .wr_hash  (cfg_hash),
      .ok       (ok_vec[k]),
      .fail     (fail_vec[k]),
      .cmp_user (user_q),
      .hit      (ent_hit[k]),
      .hash     (ent_hash[k]),
      .fail_cnt (ent_fail[k]),
      .locked   (ent_locked[k])
    );
  end

  // Lowest matching index wins when a username is duplicated.
  logic          hit_any;
  logic [AW-1:0] hit_idx;
  always_comb begin
    hit_any = 1'b0;
    hit_idx = '0;
    for (int k = USERS - 1; k >= 0; k--) begin
      if (ent_hit[k]) begin
        hit_any = 1'b1;
        hit_idx = AW'(k);
      end
    end
  end

  logic sel_locked, h_eq, chk_ok, chk_fail, fail_lock;
  assign sel_locked = ent_locked[hit_idx];
  assign h_eq       = (h == ent_hash[hit_idx]);
  assign chk_ok     = (state == CHECK) && hit_any && !sel_locked && h_eq;
  assign chk_fail   = (state == CHECK) && hit_any && !sel_locked && !h_eq;
  assign fail_lock  = (ent_fail[hit_idx] + 4'd1) == MF;

  always_comb begin
    wr_vec   = '0;
    ok_vec   = '0;
    fail_vec = '0;
    for (int k = 0; k < USERS; k++) begin
      wr_vec[k]   = cfg_we && (state == IDLE) && (cfg_addr == AW'(k));
      ok_vec[k]   = chk_ok && (hit_idx == AW'(k));
      fail_vec[k] = chk_fail && (hit_idx == AW'(k));
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      user_q      <= '0;
      pass_q      <= '0;
      len_q       <= '0;
      h           <= '0;
      i           <= '0;
      resp_valid  <= 1'b0;
      resp_pass   <= 1'b0;
      resp_locked <= 1'b0;
    end else begin
      case (state)
        IDLE: if (req_valid) begin
          user_q <= req_user;
          pass_q <= req_pass;
          len_q  <= len_c;
          h      <= FNV_OFF;
          i      <= '0;
          state  <= (len_c == '0) ? CHECK : HASH;
        end
        HASH: begin
          h <= h_next;
          i <= i + IW'(1);
          if (i == len_q - IW'(1)) state <= CHECK;
        end
        CHECK: begin
          resp_valid  <= 1'b1;
          resp_pass   <= chk_ok;
          resp_locked <= hit_any && (sel_locked || (!h_eq && fail_lock));
          state       <= RESP;
        end
        RESP: if (resp_ready) begin
          resp_valid <= 1'b0;
          state      <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_seq_verifier.sv
module tb_seq_verifier;
  localparam int DW = 64;
  localparam int NU = 8;
  localparam int MF = 3;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          req_valid = 1'b0, req_ready;
  logic [DW-1:0] req_user = '0, req_pass = '0;
  logic          resp_valid, resp_ready = 1'b1, resp_pass, resp_locked;
  logic          cfg_we = 1'b0;
  logic [2:0]    cfg_addr = '0;
  logic [DW-1:0] cfg_user = '0;
  logic [31:0]   cfg_hash = '0;

  int total = 0, bad = 0;

  seq_verifier #(.DATA_W(DW), .USERS(NU), .MAX_FAIL(MF)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_user(req_user), .req_pass(req_pass),
    .resp_valid(resp_valid), .resp_ready(resp_ready),
    .resp_pass(resp_pass), .resp_locked(resp_locked),
    .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_user(cfg_user), .cfg_hash(cfg_hash)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  // ---------------- reference model ----------------
  bit          m_valid [NU];
  logic [63:0] m_user  [NU];
  logic [31:0] m_hash  [NU];
  int          m_fail  [NU];
  bit          m_lock  [NU];

  function automatic int plen(input logic [63:0] p);
    for (int b = 0; b < 8; b++) if (p[8*b +: 8] == 8'h00) return b;
    return 8;
  endfunction

  function automatic logic [31:0] fnv(input logic [63:0] p);
    logic [31:0] x = 32'h811C9DC5;
    for (int b = 0; b < plen(p); b++) x = (x ^ {24'h0, p[8*b +: 8]}) * 32'h01000193;
    return x;
  endfunction

  function automatic void model_clear();
    for (int k = 0; k < NU; k++) begin
      m_valid[k] = 0; m_user[k] = '0; m_hash[k] = '0; m_fail[k] = 0; m_lock[k] = 0;
    end
  endfunction

  function automatic void model_req(input logic [63:0] u, p,
                                    output logic ep, el, output int elat);
    int idx = -1;
    elat = plen(p) + 2;
    for (int k = 0; k < NU; k++) if (idx < 0 && m_valid[k] && m_user[k] == u) idx = k;
    ep = 0; el = 0;
    if (idx >= 0) begin
      if (m_lock[idx]) el = 1;
      else if (fnv(p) == m_hash[idx]) begin ep = 1; m_fail[idx] = 0; end
      else begin
        if (m_fail[idx] < MF) m_fail[idx]++;
        if (m_fail[idx] == MF) begin m_lock[idx] = 1; el = 1; end
      end
    end
  endfunction

  function automatic logic [63:0] rand_pass();
    logic [63:0] p = '0;
    int l = $urandom_range(0, 8);
    for (int b = 0; b < 8; b++)
      p[8*b +: 8] = (b < l) ? 8'($urandom_range(1, 255)) : (b == l) ? 8'h00 : 8'($urandom_range(0, 255));
    return p;
  endfunction

  // ---------------- stimulus helpers ----------------
  task automatic cfg_write(input int a, input logic [63:0] u, input logic [31:0] hh);
    int n = 0;
    @(negedge clk);
    while (!req_ready && n < 100) begin @(negedge clk); n++; end
    cfg_we = 1; cfg_addr = 3'(a); cfg_user = u; cfg_hash = hh;
    @(negedge clk);
    cfg_we = 0;
    m_valid[a] = (u != 0); m_user[a] = u; m_hash[a] = hh; m_fail[a] = 0; m_lock[a] = 0;
  endtask

  // Issues one request; returns verdict and edges from accept (inclusive) to resp_valid.
  task automatic do_req(input logic [63:0] u, p, output logic gp, gl, output int lat);
    int n = 0;
    @(negedge clk);
    req_user = u; req_pass = p; req_valid = 1;
    while (!req_ready && n < 100) begin @(negedge clk); n++; end
    @(posedge clk); #1;
    req_valid = 0; lat = 1;
    while (!resp_valid && lat < 100) begin @(posedge clk); #1; lat++; end
    if (!resp_valid) lat = 999;
    gp = resp_pass; gl = resp_locked;
    if (resp_ready) begin @(posedge clk); #1; end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      total++;
      if ({req_ready, resp_valid, resp_pass, resp_locked} !== 4'b1000) begin
        bad++;
        $display("FAIL reset_outputs got=%b exp=1000", {req_ready, resp_valid, resp_pass, resp_locked});
      end
    end
    rst_n = 1;
    model_clear();
  endtask

  task automatic test_basic();
    logic gp, gl, ep, el; int lat, elat;
    cfg_write(0, 64'h61, 32'hE40C292C);
    do_req(64'h61, 64'h61, gp, gl, lat);
    model_req(64'h61, 64'h61, ep, el, elat);
    total++;
    if ({gp, gl} !== 2'b10) begin bad++; $display("FAIL basic_verdict got=%b exp=10", {gp, gl}); end
    total++;
    if (lat !== 3) begin bad++; $display("FAIL basic_latency got=%0d exp=3", lat); end
  endtask

  task automatic test_lockout();
    logic gp, gl, ep, el; int lat, elat;
    logic [2:0] exp_l = 3'b100;  // locked flag per wrong attempt, attempt 0 in bit 0... reversed below
    for (int a = 0; a < 3; a++) begin
      do_req(64'h61, 64'h62, gp, gl, lat);
      model_req(64'h61, 64'h62, ep, el, elat);
      total++;
      if ({gp, gl} !== {1'b0, exp_l[a]}) begin
        bad++; $display("FAIL lockout_wrong%0d got=%b exp=%b", a, {gp, gl}, {1'b0, exp_l[a]});
      end
    end
    do_req(64'h61, 64'h61, gp, gl, lat);
    model_req(64'h61, 64'h61, ep, el, elat);
    total++;
    if ({gp, gl} !== 2'b01) begin bad++; $display("FAIL lockout_correct got=%b exp=01", {gp, gl}); end
    // Rewrite clears the lock and the counter.
    cfg_write(0, 64'h61, 32'hE40C292C);
    do_req(64'h61, 64'h61, gp, gl, lat);
    model_req(64'h61, 64'h61, ep, el, elat);
    total++;
    if ({gp, gl} !== 2'b10) begin bad++; $display("FAIL rewrite_unlock got=%b exp=10", {gp, gl}); end
    for (int a = 0; a < 2; a++) begin
      do_req(64'h61, 64'h62, gp, gl, lat);
      model_req(64'h61, 64'h62, ep, el, elat);
      total++;
      if ({gp, gl} !== 2'b00) begin bad++; $display("FAIL rewrite_failcnt%0d got=%b exp=00", a, {gp, gl}); end
    end
    do_req(64'h61, 64'h61, gp, gl, lat);
    model_req(64'h61, 64'h61, ep, el, elat);
    total++;
    if ({gp, gl} !== 2'b10) begin bad++; $display("FAIL success_clears got=%b exp=10", {gp, gl}); end
  endtask

  task automatic test_empty_pass();
    logic gp, gl, ep, el; int lat, elat;
    cfg_write(1, 64'h6E6F70, 32'h811C9DC5);
    do_req(64'h6E6F70, 64'h0, gp, gl, lat);
    model_req(64'h6E6F70, 64'h0, ep, el, elat);
    total++;
    if ({gp, gl} !== 2'b10) begin bad++; $display("FAIL empty_verdict got=%b exp=10", {gp, gl}); end
    total++;
    if (lat !== 2) begin bad++; $display("FAIL empty_latency got=%0d exp=2", lat); end
    do_req(64'h7A7A7A, 64'h61, gp, gl, lat);
    model_req(64'h7A7A7A, 64'h61, ep, el, elat);
    total++;
    if ({gp, gl} !== 2'b00) begin bad++; $display("FAIL unknown_user got=%b exp=00", {gp, gl}); end
  endtask

  task automatic test_duplicate();
    logic gp, gl, ep, el; int lat, elat;
    logic [63:0] u = 64'h6475_70, p = 64'h0000_7778_797A;
    cfg_write(2, u, fnv(p));
    cfg_write(5, u, 32'h1234_5678);
    do_req(u, p, gp, gl, lat);
    model_req(u, p, ep, el, elat);
    total++;
    if ({gp, gl} !== 2'b10) begin bad++; $display("FAIL dup_lowest got=%b exp=10", {gp, gl}); end
    for (int a = 0; a < MF; a++) begin
      do_req(u, 64'h31, gp, gl, lat);
      model_req(u, 64'h31, ep, el, elat);
      total++;
      if ({gp, gl} !== {ep, el}) begin bad++; $display("FAIL dup_fail%0d got=%b exp=%b", a, {gp, gl}, {ep, el}); end
    end
  endtask

  task automatic test_cfg_during_hash();
    logic ep, el; int elat, n;
    logic [63:0] u = 64'h4242, p = 64'h3837_3635_3433_3231;
    cfg_write(1, u, fnv(p));
    @(negedge clk);
    req_user = u; req_pass = p; req_valid = 1;
    @(posedge clk); #1;
    req_valid = 0;
    @(negedge clk);
    cfg_we = 1; cfg_addr = 3'd1; cfg_user = u; cfg_hash = 32'hDEAD_BEEF;
    @(negedge clk);
    cfg_we = 0;
    n = 0;
    while (!resp_valid && n < 100) begin @(posedge clk); #1; n++; end
    model_req(u, p, ep, el, elat);
    total++;
    if ({resp_valid, resp_pass, resp_locked} !== 3'b110) begin
      bad++; $display("FAIL cfg_in_hash got=%b exp=110", {resp_valid, resp_pass, resp_locked});
    end
    @(posedge clk); #1;
  endtask

  task automatic test_backpressure();
    logic gp, gl, ep, el, p2, l2; int lat, elat, n;
    logic [63:0] u = 64'h61, p = 64'h62;
    resp_ready = 0;
    do_req(u, p, gp, gl, lat);
    model_req(u, p, ep, el, elat);
    total++;
    if ({gp, gl} !== {ep, el} || lat !== elat) begin
      bad++; $display("FAIL bp_first got=%b/%0d exp=%b/%0d", {gp, gl}, lat, {ep, el}, elat);
    end
    for (int c = 0; c < 10; c++) begin
      @(posedge clk); #1;
      total++;
      if ({resp_valid, resp_pass, resp_locked, req_ready} !== {1'b1, ep, el, 1'b0}) begin
        bad++; $display("FAIL bp_hold%0d got=%b exp=%b", c,
          {resp_valid, resp_pass, resp_locked, req_ready}, {1'b1, ep, el, 1'b0});
      end
    end
    // Request pending while the response completes: not accepted on that edge.
    @(negedge clk);
    req_user = u; req_pass = 64'h0; req_valid = 1; resp_ready = 1;
    @(posedge clk); #1;
    total++;
    if ({resp_valid, req_ready} !== 2'b01) begin
      bad++; $display("FAIL bp_release got=%b exp=01", {resp_valid, req_ready});
    end
    @(posedge clk); #1;
    req_valid = 0;
    total++;
    if (req_ready !== 1'b0) begin bad++; $display("FAIL bp_next_accept got=%b exp=0", req_ready); end
    n = 1;
    while (!resp_valid && n < 100) begin @(posedge clk); #1; n++; end
    p2 = resp_pass; l2 = resp_locked;
    model_req(u, 64'h0, ep, el, elat);
    total++;
    if ({resp_valid, p2, l2} !== {1'b1, ep, el} || n !== elat) begin
      bad++; $display("FAIL bp_second got=%b/%0d exp=%b/%0d", {resp_valid, p2, l2}, n, {1'b1, ep, el}, elat);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_random();
    logic [63:0] ru[4], rp[4], u, p;
    logic gp, gl, ep, el; int lat, elat, k;
    for (int j = 0; j < 4; j++) begin
      ru[j] = {$urandom, $urandom} | 64'h1;
      rp[j] = rand_pass();
      cfg_write(j + 4, ru[j], fnv(rp[j]));
    end
    for (int it = 0; it < 120; it++) begin
      k = $urandom_range(0, 3);
      if ($urandom_range(0, 9) < 2) begin
        cfg_write($urandom_range(0, NU - 1), ($urandom_range(0, 7) == 0) ? 64'h0 : ru[k],
                  ($urandom_range(0, 3) == 0) ? 32'($urandom) : fnv(rp[k]));
      end else begin
        u = ($urandom_range(0, 9) == 0) ? {$urandom, $urandom} : ru[k];
        p = ($urandom_range(0, 9) < 6) ? rp[k] : rand_pass();
        do_req(u, p, gp, gl, lat);
        model_req(u, p, ep, el, elat);
        total++;
        if ({gp, gl} !== {ep, el} || lat !== elat) begin
          bad++; $display("FAIL rand%0d got=%b/%0d exp=%b/%0d", it, {gp, gl}, lat, {ep, el}, elat);
        end
      end
    end
  endtask

  task automatic test_reset_mid();
    logic gp, gl, ep, el; int lat, elat;
    logic [63:0] u = 64'h5A5A, p = 64'h4847_4645_4443_4241;
    cfg_write(3, u, fnv(p));
    @(negedge clk);
    req_user = u; req_pass = p; req_valid = 1;
    @(posedge clk); #1;
    req_valid = 0;
    @(posedge clk); #2;
    rst_n = 0;
    #1;
    total++;
    if ({req_ready, resp_valid, resp_pass, resp_locked} !== 4'b1000) begin
      bad++; $display("FAIL reset_mid got=%b exp=1000", {req_ready, resp_valid, resp_pass, resp_locked});
    end
    model_clear();
    @(negedge clk); @(negedge clk);
    rst_n = 1;
    for (int c = 0; c < 12; c++) begin
      @(posedge clk); #1;
      total++;
      if (resp_valid !== 1'b0) begin bad++; $display("FAIL reset_abort%0d got=%b exp=0", c, resp_valid); end
    end
    do_req(u, p, gp, gl, lat);
    model_req(u, p, ep, el, elat);
    total++;
    if ({gp, gl} !== 2'b00 || lat !== elat) begin
      bad++; $display("FAIL reset_table got=%b/%0d exp=00/%0d", {gp, gl}, lat, elat);
    end
  endtask

  initial begin
    model_clear();
    test_reset();
    test_basic();
    test_lockout();
    test_empty_pass();
    test_duplicate();
    test_cfg_during_hash();
    test_backpressure();
    test_random();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
